// File: rtl/shift_pkg.sv
// Shared encodings and default sizing for the multi-cycle shift/rotate sequencer.
package shift_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_stage.sv
// One logarithmic shift/rotate stage, time-shared by the sequencer.
// Amount is one-hot; the input passes through unchanged when disabled.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [WIDTH-1:0] data_i,
  input  op_e              op_i,
  input  logic [CNT_W-1:0] amt_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o
);

  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] rol_w;
  logic [2*WIDTH-1:0] ror_w;
  logic [WIDTH-1:0]   shifted;
  int                 sh;

  always_comb begin
    sh = 0;
    for (int i = 0; i < CNT_W; i++) begin
      if (amt_i[i]) sh = 1 << i;
    end
    // Rotations fall out of shifting a doubled copy of the operand.
    dbl   = {data_i, data_i};
    rol_w = dbl << sh;
    ror_w = dbl >> sh;
    case (op_i)
      OP_ROL:  shifted = rol_w[2*WIDTH-1:WIDTH];
      OP_SLL:  shifted = data_i << sh;
      OP_ROR:  shifted = ror_w[WIDTH-1:0];
      OP_SRL:  shifted = data_i >> sh;
      default: shifted = data_i;
    endcase
    data_o = en_i ? shifted : data_i;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate engine: applies one power-of-two stage per cycle
// through a single shared shift_stage, with valid/ready request and response.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | ready for a request; flush blocks acceptance
// ST_SHIFT | applying stage idx_q (always CNT_W cycles, no early exit)
// ST_DONE  | result held on resp_data until consumed or flushed
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_data,
  input  logic [CNT_W-1:0] req_cnt,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  input  logic             flush,
  output logic             busy
);

  localparam int IDX_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CNT_W - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_ready_q;
  logic             resp_valid_q;
  logic [WIDTH-1:0] resp_data_q;
  logic             busy_q;

  logic [WIDTH-1:0] data_d;
  logic [CNT_W-1:0] amt;

  assign amt = CNT_W'(1) << idx_q;

  shift_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_stage (
    .data_i (data_q),
    .op_i   (op_q),
    .amt_i  (amt),
    .en_i   (cnt_q[idx_q]),
    .data_o (data_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      op_q         <= OP_ROL;
      data_q       <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!flush && req_valid) begin
            state_q     <= ST_SHIFT;
            op_q        <= op_e'(req_op);
            data_q      <= req_data;
            cnt_q       <= req_cnt;
            idx_q       <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (flush) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            data_q <= data_d;
            idx_q  <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              state_q      <= ST_DONE;
              resp_valid_q <= 1'b1;
              resp_data_q  <= data_d;
            end
          end
        end
        ST_DONE: begin
          // A flush coinciding with the handshake still counts as a flush;
          // either way the result is dropped and the engine goes idle.
          if (flush || resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          resp_data_q  <= '0;
          req_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, op semantics, backpressure,
// flush and asynchronous reset.
module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_data;
  logic [3:0]  req_cnt;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        flush;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  shift_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_data   (req_data),
    .req_cnt    (req_cnt),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .flush      (flush),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: apply the operation one bit position at a time.
  function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] d,
                                            input logic [3:0] c);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < int'(c); i++) begin
      case (op)
        2'b00:   r = {r[14:0], r[15]};
        2'b01:   r = {r[14:0], 1'b0};
        2'b10:   r = {r[0], r[15:1]};
        default: r = {1'b0, r[15:1]};
      endcase
    end
    return r;
  endfunction

  // Accept a request at E0, then confirm resp_valid rises exactly at E4.
  task automatic issue(input logic [1:0] op, input logic [15:0] d, input logic [3:0] c,
                       input string tag);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    req_cnt   = c;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data  = 16'hDEAD;
    req_cnt   = 4'hF;
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " req_ready"}, 32'(req_ready), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      check({tag, " early_valid"}, 32'(resp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    check({tag, " valid_E4"}, 32'(resp_valid), 32'd1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [15:0] d, input logic [3:0] c,
                        input logic [15:0] exp, input string tag);
    issue(op, d, c, tag);
    check({tag, " data"}, 32'(resp_data), 32'(exp));
    @(posedge clk);
    #1;
    check({tag, " idle_valid"}, 32'(resp_valid), 32'd0);
    check({tag, " idle_ready"}, 32'(req_ready), 32'd1);
    check({tag, " idle_data"}, 32'(resp_data), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_data   = '0;
    req_cnt    = '0;
    resp_ready = 1'b1;
    flush      = 1'b0;
    #12;
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_data", 32'(resp_data), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b00, 16'h8001, 4'd1,  16'h0003, "rol1");
    run_op(2'b01, 16'h00FF, 4'd4,  16'h0FF0, "sll4");
    run_op(2'b10, 16'h0001, 4'd1,  16'h8000, "ror1");
    run_op(2'b11, 16'h8000, 4'd15, 16'h0001, "srl15");
    run_op(2'b00, 16'hA5C3, 4'd0,  16'hA5C3, "cnt0");
    run_op(2'b01, 16'h1234, 4'd5,  16'h4680, "sll5");
    run_op(2'b10, 16'h1234, 4'd6,  16'hD048, "ror6");

    for (int op = 0; op < 4; op++) begin
      run_op(2'(op), 16'hFFFF, 4'd15, ref_shift(2'(op), 16'hFFFF, 4'd15), "c15_ffff");
      run_op(2'(op), 16'h1234, 4'd15, ref_shift(2'(op), 16'h1234, 4'd15), "c15_1234");
    end

    // Backpressure: result and flags must hold while resp_ready is low.
    resp_ready = 1'b0;
    issue(2'b00, 16'h00F0, 4'd4, "bp");
    for (int i = 0; i < 3; i++) begin
      check("bp data", 32'(resp_data), 32'h0F00);
      check("bp valid", 32'(resp_valid), 32'd1);
      check("bp req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check("bp data_end", 32'(resp_data), 32'h0F00);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release_ready", 32'(req_ready), 32'd1);
    check("bp release_valid", 32'(resp_valid), 32'd0);

    // Flush on the 2nd SHIFT cycle.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_data  = 16'h0003;
    req_cnt   = 4'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("flush no_valid", 32'(resp_valid), 32'd0);
    end
    run_op(2'b01, 16'h0001, 4'd8, 16'h0100, "post_flush");

    // Flush beats a request in IDLE.
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_data  = 16'h1111;
    req_cnt   = 4'd1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    check("idle_flush busy", 32'(busy), 32'd0);
    check("idle_flush ready", 32'(req_ready), 32'd1);

    // Flush together with the response handshake in DONE.
    issue(2'b11, 16'hF000, 4'd4, "done_flush");
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("done_flush valid", 32'(resp_valid), 32'd0);
    check("done_flush ready", 32'(req_ready), 32'd1);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_data  = 16'h00FF;
    req_cnt   = 4'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst ready", 32'(req_ready), 32'd1);
    check("arst valid", 32'(resp_valid), 32'd0);
    check("arst data", 32'(resp_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b10, 16'h00FF, 4'd3, 16'hE01F, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
